// File: rtl/bmi_bit_gather_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bmi_bit_gather_ctrl_if : request / mux-tree / result bundle  (rev 1.0)    |
// +--------------------------------------------------------------------------+
interface bmi_bit_gather_ctrl_if #(
  parameter int SEL_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 6
);
  logic                 start_valid;
  logic                 start_ready;
  logic [SEL_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0] len;
  logic [SEL_WIDTH-1:0] mux_sel;
  logic                 mux_bit;
  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_WIDTH-1:0] result;
  logic                 busy;

  // master: issue logic + mux tree side; slave: the gather controller
  modport master (
    output start_valid, base, len, mux_bit, res_ready,
    input  start_ready, mux_sel, res_valid, result, busy
  );

  modport slave (
    input  start_valid, base, len, mux_bit, res_ready,
    output start_ready, mux_sel, res_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/bmi_bit_gather_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bmi_bit_gather_ctrl : steps the 256:1 bit mux, gathers field LSB-first    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bmi_bit_gather_ctrl #(
  parameter int SEL_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 6,
  parameter int MUX_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  bmi_bit_gather_ctrl_if.slave    bus
);

  localparam int c_idx_w = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  localparam logic [LEN_WIDTH-1:0] c_out_w = LEN_WIDTH'(OUT_WIDTH);
  localparam logic [LEN_WIDTH-1:0] c_one   = LEN_WIDTH'(1);

  logic [1:0]           r_state;
  logic [SEL_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0] r_len_eff;
  logic [LEN_WIDTH-1:0] r_k;
  logic [OUT_WIDTH-1:0] r_result;

  logic                 w_accept;
  logic                 w_issue;
  logic                 w_last_issue;
  logic                 w_cap_vld;
  logic                 w_last_cap;
  logic [LEN_WIDTH-1:0] w_len_eff;
  logic [c_idx_w-1:0]   w_issue_idx;
  logic [c_idx_w-1:0]   w_cap_idx;
  logic [c_idx_w-1:0]   w_last_idx;

  assign w_len_eff    = (bus.len > c_out_w) ? c_out_w : bus.len;
  assign w_accept     = bus.start_valid && (r_state == c_idle);
  assign w_issue      = (r_state == c_issue);
  assign w_last_issue = w_issue && (r_k == (r_len_eff - c_one));
  assign w_issue_idx  = r_k[c_idx_w-1:0];
  assign w_last_idx   = c_idx_w'(r_len_eff - c_one);
  assign w_last_cap   = w_cap_vld && (w_cap_idx == w_last_idx);

  // Tag pipe mirrors the mux tree latency so each returned bit lands at its index.
  if (MUX_LAT == 0) begin : g_comb_cap
    assign w_cap_vld = w_issue;
    assign w_cap_idx = w_issue_idx;
  end else begin : g_pipe_cap
    logic [MUX_LAT-1:0] r_pipe_vld;
    logic [c_idx_w-1:0] r_pipe_idx [MUX_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pipe_vld <= '0;
        for (int i = 0; i < MUX_LAT; i++) begin
          r_pipe_idx[i] <= '0;
        end
      end else begin
        r_pipe_vld[0] <= w_issue;
        r_pipe_idx[0] <= w_issue_idx;
        for (int i = 1; i < MUX_LAT; i++) begin
          r_pipe_vld[i] <= r_pipe_vld[i-1];
          r_pipe_idx[i] <= r_pipe_idx[i-1];
        end
      end
    end

    assign w_cap_vld = r_pipe_vld[MUX_LAT-1];
    assign w_cap_idx = r_pipe_idx[MUX_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_idle;
      r_base    <= '0;
      r_len_eff <= '0;
      r_k       <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_base    <= bus.base;
            r_len_eff <= w_len_eff;
            r_k       <= '0;
            r_result  <= '0;
            r_state   <= (w_len_eff == '0) ? c_done : c_issue;
          end
        end
        c_issue: begin
          if (w_last_issue) begin
            r_k     <= '0;
            r_state <= (MUX_LAT == 0) ? c_done : c_drain;
          end else begin
            r_k <= r_k + c_one;
          end
        end
        c_drain: begin
          if (w_last_cap) begin
            r_state <= c_done;
          end
        end
        c_done: begin
          if (bus.res_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase

      if (w_cap_vld) begin
        r_result[w_cap_idx] <= bus.mux_bit;
      end
    end
  end

  // Select wraps modulo 2^SEL_WIDTH through the natural adder overflow.
  assign bus.mux_sel     = w_issue ? (r_base + SEL_WIDTH'(r_k)) : '0;
  assign bus.start_ready = (r_state == c_idle);
  assign bus.res_valid   = (r_state == c_done);
  assign bus.busy        = (r_state != c_idle);
  assign bus.result      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_bmi_bit_gather_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bmi_bit_gather_ctrl : randomized bench with field-extract ref model    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_bmi_bit_gather_ctrl;
  localparam int SEL_WIDTH = 8;
  localparam int OUT_WIDTH = 32;
  localparam int LEN_WIDTH = 6;
  localparam int MUX_LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [255:0]         src = '0;
  logic [SEL_WIDTH-1:0] d1 = '0;
  logic [SEL_WIDTH-1:0] d2 = '0;

  always #5 clk = ~clk;

  bmi_bit_gather_ctrl_if #(
    .SEL_WIDTH(SEL_WIDTH), .OUT_WIDTH(OUT_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) bus ();

  bmi_bit_gather_ctrl #(
    .SEL_WIDTH(SEL_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .LEN_WIDTH(LEN_WIDTH), .MUX_LAT(MUX_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Mux tree: source[sel] appears two cycles after sel is driven.
  always @(posedge clk) begin
    d1 <= bus.mux_sel;
    d2 <= d1;
  end
  assign bus.mux_bit = src[d2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [255:0] s, input int b, input int l);
    logic [31:0] r;
    int leff;
    r    = '0;
    leff = (l > OUT_WIDTH) ? OUT_WIDTH : l;
    for (int i = 0; i < leff; i++) r[i] = s[(b + i) % 256];
    return r;
  endfunction

  task automatic randomize_src();
    for (int i = 0; i < 8; i++) src[i*32 +: 32] = $urandom;
  endtask

  task automatic run_req(input int b, input int l, input int hold, output logic [31:0] got);
    int          leff;
    int          exp_lat;
    int          cyc;
    logic [31:0] exp_res;
    leff    = (l > OUT_WIDTH) ? OUT_WIDTH : l;
    exp_lat = (leff == 0) ? 1 : leff + MUX_LAT + 1;
    exp_res = model_result(src, b, l);

    @(negedge clk);
    check_eq("idle_start_ready", bus.start_ready, 1);
    bus.start_valid = 1'b1;
    bus.base        = b[SEL_WIDTH-1:0];
    bus.len         = l[LEN_WIDTH-1:0];
    @(negedge clk);
    cyc = 1;
    while (!bus.res_valid && cyc < 200) begin
      check_eq("mux_sel", bus.mux_sel, (cyc <= leff) ? (b + cyc - 1) % 256 : 0);
      check_eq("busy", bus.busy, 1);
      check_eq("start_ready_busy", bus.start_ready, 0);
      bus.start_valid = 1'($urandom_range(0, 1));
      bus.base        = SEL_WIDTH'($urandom);
      bus.len         = LEN_WIDTH'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.start_valid = 1'b0;
    check_eq("latency", cyc, exp_lat);
    check_eq("result", bus.result, exp_res);
    check_eq("mux_sel_done", bus.mux_sel, 0);
    got = bus.result;

    for (int h = 0; h < hold; h++) begin
      bus.res_ready   = 1'b0;
      bus.start_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("hold_res_valid", bus.res_valid, 1);
      check_eq("hold_result", bus.result, exp_res);
      check_eq("hold_start_ready", bus.start_ready, 0);
    end

    // A start arriving alongside the completing res_ready must be dropped.
    bus.res_ready   = 1'b1;
    bus.start_valid = 1'b1;
    bus.base        = SEL_WIDTH'($urandom);
    bus.len         = LEN_WIDTH'($urandom_range(1, 63));
    @(negedge clk);
    bus.res_ready   = 1'b0;
    bus.start_valid = 1'b0;
    check_eq("post_res_valid", bus.res_valid, 0);
    check_eq("post_start_ready", bus.start_ready, 1);
    check_eq("post_busy", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]          got;
    logic [SEL_WIDTH-1:0] rb;
    int                   seen;

    bus.start_valid = 1'b0;
    bus.base        = '0;
    bus.len         = '0;
    bus.res_ready   = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_start_ready", bus.start_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_mux_sel", bus.mux_sel, 0);
    check_eq("rst_result", bus.result, 0);

    randomize_src();
    src[7:0] = 8'hA5;
    run_req(0, 8, 0, got);
    check_eq("field_a5", got, 32'h0000_00A5);

    src[0] = 1'b1; src[1] = 1'b1; src[254] = 1'b1; src[255] = 1'b0;
    run_req(254, 4, 0, got);
    check_eq("field_wrap", got, 32'h0000_000D);

    run_req(5, 0, 0, got);
    check_eq("field_len0", got, 32'h0);

    randomize_src();
    run_req(10, 40, 0, got);
    run_req(3, 20, 10, got);

    // Abort at issue k=3 of a 16-bit request.
    randomize_src();
    rb = SEL_WIDTH'($urandom);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.base        = rb;
    bus.len         = LEN_WIDTH'(16);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_mux_sel_k3", bus.mux_sel, SEL_WIDTH'(rb + 8'd3));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_start_ready", bus.start_ready, 1);
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_res_valid", bus.res_valid, 0);
    check_eq("abort_mux_sel", bus.mux_sel, 0);
    check_eq("abort_result", bus.result, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    check_eq("abort_no_partial", seen, 0);
    run_req(16, 16, 0, got);

    for (int t = 0; t < 20; t++) begin
      randomize_src();
      run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 3)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
